// File: rtl/i2s_rx_multichannel.sv
// rtl/i2s_rx_multichannel.sv - multi-line I2S receiver sharing one word-select
//
// Deserialises NUM_LINES serial data lines on the bit clock. Each slot is captured
// MSB-first and truncated to SAMPLE_BITS. A left slot followed by a right slot,
// both exactly SLOT_BITS long, is published on the falling ws edge that closes the
// right slot. Slots of the wrong length raise frame_error and force a resync.
//
// Ports:
//   clk          bit clock, all logic on posedge
//   reset        synchronous, active-high
//   ws           word select (0 = left, 1 = right)
//   data_in      serial data, bit i = line i
//   left_out     published left samples, line i at [i*SAMPLE_BITS +: SAMPLE_BITS]
//   right_out    published right samples, same packing
//   sample_valid one-cycle pulse when left_out/right_out update
//   frame_error  one-cycle pulse when a tracked slot had the wrong length
module i2s_rx_multichannel #(
  parameter int NUM_LINES   = 2,
  parameter int SAMPLE_BITS = 8,
  parameter int SLOT_BITS   = 32,
  parameter int DELAY       = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ws,
  input  logic [NUM_LINES-1:0]             data_in,
  output logic [NUM_LINES*SAMPLE_BITS-1:0] left_out,
  output logic [NUM_LINES*SAMPLE_BITS-1:0] right_out,
  output logic                             sample_valid,
  output logic                             frame_error
);

  // slot_cnt saturates at SLOT_BITS+1 and slot_pos can reach one more than that
  localparam int CW       = $clog2(SLOT_BITS + 3);
  localparam int LAST_POS = DELAY + SAMPLE_BITS - 1;

  typedef enum logic [1:0] {SYNC, CAPTURE, HOLD} state_t;

  state_t                 state;
  logic                   prev_ws;
  logic                   primed;
  logic                   chan;      // channel of the slot in progress, 0 = left
  logic [CW-1:0]          slot_cnt;
  logic [SAMPLE_BITS-1:0] sh_l [NUM_LINES];
  logic [SAMPLE_BITS-1:0] sh_r [NUM_LINES];

  logic          edge_det;
  logic          len_ok;
  logic          start_slot;
  logic          cap_en;
  logic          cap_chan;
  logic          cap_last;
  logic [CW-1:0] slot_pos;

  always_comb begin
    edge_det = primed && (ws != prev_ws);
    // slot_cnt lags the slot position by one, so a full slot closes at SLOT_BITS-1
    len_ok   = (slot_cnt == CW'(SLOT_BITS - 1));
    slot_pos = edge_det ? '0 : slot_cnt + 1'b1;
    // a slot is tracked from every falling edge, and from a rising edge that
    // cleanly closes a tracked left slot
    start_slot = edge_det && (!ws || ((state != SYNC) && len_ok));
    cap_chan   = edge_det ? ws : chan;
    // left-justified mode takes the MSB in the edge cycle itself
    cap_en     = (start_slot && (DELAY == 0)) || (!edge_det && (state == CAPTURE));
    cap_last   = (slot_pos == CW'(LAST_POS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SYNC;
      prev_ws      <= 1'b0;
      primed       <= 1'b0;
      chan         <= 1'b0;
      slot_cnt     <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        sh_l[i] <= '0;
        sh_r[i] <= '0;
      end
    end else begin
      prev_ws      <= ws;
      primed       <= 1'b1;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (edge_det) begin
        slot_cnt <= '0;
      end else if (slot_cnt != CW'(SLOT_BITS + 1)) begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // length checks apply only to slots we were tracking
      if (edge_det && (state != SYNC)) begin
        if (!len_ok) begin
          frame_error <= 1'b1;
        end else if (!ws) begin
          for (int i = 0; i < NUM_LINES; i++) begin
            left_out[i*SAMPLE_BITS +: SAMPLE_BITS]  <= sh_l[i];
            right_out[i*SAMPLE_BITS +: SAMPLE_BITS] <= sh_r[i];
          end
          sample_valid <= 1'b1;
        end
      end

      if (start_slot) begin
        chan  <= ws;
        state <= CAPTURE;
      end else if (edge_det && (state != SYNC)) begin
        state <= SYNC;
      end

      if (cap_en) begin
        for (int i = 0; i < NUM_LINES; i++) begin
          if (cap_chan) begin
            sh_r[i] <= (sh_r[i] << 1) | SAMPLE_BITS'(data_in[i]);
          end else begin
            sh_l[i] <= (sh_l[i] << 1) | SAMPLE_BITS'(data_in[i]);
          end
        end
        if (cap_last) begin
          state <= HOLD;
        end
      end
    end
  end

endmodule
